// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Framed program loader sitting between a UART receiver/transmitter pair and
// a banked instruction memory.  A frame is a word-count header N, N words of
// WORD_BYTES bytes each, then an 8-bit additive checksum.  Every assembled
// word is written into the active bank; the frame is answered with ACK (06)
// or NAK (15).  An optional idle-gap timeout aborts stalled frames.
//
// Ports
//   i_clk           clock
//   i_arst_n        synchronous active-low reset
//   i_rx_valid      1-cycle strobe, i_rx_byte valid
//   i_rx_byte       received byte
//   i_next_program  release the verified program, advance to the next bank
//   i_tx_done       transmitter finished the response byte
//   o_tx_start      1-cycle pulse to start sending o_tx_byte
//   o_tx_byte       response byte (ACK 06 / NAK 15), held until replaced
//   o_mem_we        1-cycle memory write strobe
//   o_mem_addr      bank*BANK_DEPTH + word index
//   o_mem_wdata     assembled word
//   o_prog_rdy      active bank holds a verified program
//   o_busy          high in DATA, CHECK and RESP
//   o_err           sticky NAK flag, cleared by the next header byte
//   o_n_words       word count of the last header
//   o_bank          active bank
//   o_state         FSM encoding (debug)
// -----------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int  WORD_BYTES  = 4,
   parameter int  BYTE_WIDTH  = 8,
   parameter int  BANK_DEPTH  = 64,
   parameter int  NUM_BANKS   = 2,
   parameter int  BIG_ENDIAN  = 0,
   parameter int  TIMEOUT_CYC = 0,
   localparam int DATA_WIDTH  = WORD_BYTES * BYTE_WIDTH,
   localparam int ADDR_WIDTH  = (NUM_BANKS * BANK_DEPTH > 1) ? $clog2(NUM_BANKS * BANK_DEPTH) : 1,
   localparam int BANK_WIDTH  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_arst_n,
   input  logic                  i_rx_valid,
   input  logic [BYTE_WIDTH-1:0] i_rx_byte,
   input  logic                  i_next_program,
   input  logic                  i_tx_done,
   output logic                  o_tx_start,
   output logic [BYTE_WIDTH-1:0] o_tx_byte,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_prog_rdy,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [7:0]            o_n_words,
   output logic [BANK_WIDTH-1:0] o_bank,
   output logic [2:0]            o_state
);

   localparam int BIDX_WIDTH = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int GAP_WIDTH  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [BYTE_WIDTH-1:0] ACK_BYTE = BYTE_WIDTH'(8'h06);
   localparam logic [BYTE_WIDTH-1:0] NAK_BYTE = BYTE_WIDTH'(8'h15);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DATA  = 3'd1,
      S_CHECK = 3'd2,
      S_RESP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   logic [7:0]            r_n_words;
   logic [7:0]            r_sum;
   logic                  r_err;
   logic                  r_ack;
   logic [BANK_WIDTH-1:0] r_bank;
   logic [7:0]            r_word_idx;
   logic [BIDX_WIDTH-1:0] r_byte_idx;
   logic [GAP_WIDTH-1:0]  r_gap;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_tx_start;
   logic [BYTE_WIDTH-1:0] r_tx_byte;
   logic                  r_prog_rdy;

   logic [7:0]            w_rx8;
   logic [DATA_WIDTH-1:0] w_word_next;
   logic                  w_last_byte;
   logic                  w_last_word;
   logic                  w_hdr_bad;
   logic                  w_timeout;
   logic [ADDR_WIDTH-1:0] w_addr;

   assign w_rx8       = 8'(i_rx_byte);
   assign w_last_byte = (r_byte_idx == BIDX_WIDTH'(WORD_BYTES - 1));
   assign w_last_word = (r_word_idx == (r_n_words - 8'd1));
   assign w_hdr_bad   = (w_rx8 == 8'd0) || (int'(w_rx8) > BANK_DEPTH);
   assign w_timeout   = (TIMEOUT_CYC > 0) && !i_rx_valid &&
                        (r_gap == GAP_WIDTH'(TIMEOUT_CYC - 1));
   assign w_addr      = ADDR_WIDTH'(r_bank) * ADDR_WIDTH'(BANK_DEPTH) + ADDR_WIDTH'(r_word_idx);

   // Shift-based assembly keeps WORD_BYTES==1 legal (no negative slices).
   // Little-endian shifts right so the first byte ends up in the LSB after
   // WORD_BYTES bytes; big-endian shifts left so it ends up in the MSB.
   always_comb begin
      w_word_next = '0;
      if (BIG_ENDIAN != 0) begin
         w_word_next                   = r_shift << BYTE_WIDTH;
         w_word_next[BYTE_WIDTH-1:0]   = i_rx_byte;
      end else begin
         w_word_next                          = r_shift >> BYTE_WIDTH;
         w_word_next[DATA_WIDTH-1 -: BYTE_WIDTH] = i_rx_byte;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_arst_n) begin
         r_state     <= S_IDLE;
         r_n_words   <= '0;
         r_sum       <= '0;
         r_err       <= 1'b0;
         r_ack       <= 1'b0;
         r_bank      <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_gap       <= '0;
         r_shift     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_tx_start  <= 1'b0;
         r_tx_byte   <= '0;
         r_prog_rdy  <= 1'b0;
      end else begin
         r_mem_we   <= 1'b0;
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_rx_valid) begin
                  r_n_words  <= w_rx8;
                  r_sum      <= w_rx8;
                  r_err      <= 1'b0;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  r_gap      <= '0;
                  if (w_hdr_bad) begin
                     r_err      <= 1'b1;
                     r_ack      <= 1'b0;
                     r_tx_byte  <= NAK_BYTE;
                     r_tx_start <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     r_state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (i_rx_valid) begin
                  r_gap   <= '0;
                  r_sum   <= r_sum + w_rx8;
                  r_shift <= w_word_next;
                  if (w_last_byte) begin
                     r_byte_idx  <= '0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_addr;
                     r_mem_wdata <= w_word_next;
                     r_word_idx  <= r_word_idx + 8'd1;
                     if (w_last_word) r_state <= S_CHECK;
                  end else begin
                     r_byte_idx <= r_byte_idx + BIDX_WIDTH'(1);
                  end
               end else if (w_timeout) begin
                  // partial word is simply abandoned; no write is issued
                  r_err      <= 1'b1;
                  r_ack      <= 1'b0;
                  r_tx_byte  <= NAK_BYTE;
                  r_tx_start <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_gap <= r_gap + GAP_WIDTH'(1);
               end
            end
            S_CHECK: begin
               if (i_rx_valid) begin
                  r_gap      <= '0;
                  r_tx_start <= 1'b1;
                  r_state    <= S_RESP;
                  if (w_rx8 == r_sum) begin
                     r_ack     <= 1'b1;
                     r_tx_byte <= ACK_BYTE;
                  end else begin
                     r_ack     <= 1'b0;
                     r_err     <= 1'b1;
                     r_tx_byte <= NAK_BYTE;
                  end
               end else if (w_timeout) begin
                  r_err      <= 1'b1;
                  r_ack      <= 1'b0;
                  r_tx_byte  <= NAK_BYTE;
                  r_tx_start <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_gap <= r_gap + GAP_WIDTH'(1);
               end
            end
            S_RESP: begin
               if (i_tx_done) begin
                  if (r_ack) begin
                     r_prog_rdy <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               if (i_next_program) begin
                  r_prog_rdy <= 1'b0;
                  r_bank     <= (r_bank == BANK_WIDTH'(NUM_BANKS - 1)) ? '0 : r_bank + BANK_WIDTH'(1);
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_tx_start  = r_tx_start;
   assign o_tx_byte   = r_tx_byte;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_prog_rdy  = r_prog_rdy;
   assign o_busy      = (r_state == S_DATA) || (r_state == S_CHECK) || (r_state == S_RESP);
   assign o_err       = r_err;
   assign o_n_words   = r_n_words;
   assign o_bank      = r_bank;
   assign o_state     = r_state;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
// Drives one byte stream into a little-endian and a big-endian loader (both
// with a 100-cycle idle timeout) and checks both against a frame-level model
// every cycle, plus literal expectations for the documented example frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_prog_loader;

   localparam int WB    = 4;
   localparam int DEPTH = 64;
   localparam int NB    = 2;
   localparam int TO    = 100;
   localparam int AW    = 7;
   localparam int DW    = 32;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       next_program = 1'b0;
   logic       tx_done = 1'b0;

   logic          le_tx_start, le_mem_we, le_prog_rdy, le_busy, le_err;
   logic [7:0]    le_tx_byte, le_n_words;
   logic [AW-1:0] le_mem_addr;
   logic [DW-1:0] le_mem_wdata;
   logic [0:0]    le_bank;
   logic [2:0]    le_state;

   logic          be_tx_start, be_mem_we, be_prog_rdy, be_busy, be_err;
   logic [7:0]    be_tx_byte, be_n_words;
   logic [AW-1:0] be_mem_addr;
   logic [DW-1:0] be_mem_wdata;
   logic [0:0]    be_bank;
   logic [2:0]    be_state;

   uart_prog_loader #(.WORD_BYTES(WB), .BYTE_WIDTH(8), .BANK_DEPTH(DEPTH), .NUM_BANKS(NB),
                      .BIG_ENDIAN(0), .TIMEOUT_CYC(TO)) u_le (
      .i_clk(clk), .i_arst_n(arst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
      .i_next_program(next_program), .i_tx_done(tx_done),
      .o_tx_start(le_tx_start), .o_tx_byte(le_tx_byte), .o_mem_we(le_mem_we),
      .o_mem_addr(le_mem_addr), .o_mem_wdata(le_mem_wdata), .o_prog_rdy(le_prog_rdy),
      .o_busy(le_busy), .o_err(le_err), .o_n_words(le_n_words), .o_bank(le_bank),
      .o_state(le_state));

   uart_prog_loader #(.WORD_BYTES(WB), .BYTE_WIDTH(8), .BANK_DEPTH(DEPTH), .NUM_BANKS(NB),
                      .BIG_ENDIAN(1), .TIMEOUT_CYC(TO)) u_be (
      .i_clk(clk), .i_arst_n(arst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
      .i_next_program(next_program), .i_tx_done(tx_done),
      .o_tx_start(be_tx_start), .o_tx_byte(be_tx_byte), .o_mem_we(be_mem_we),
      .o_mem_addr(be_mem_addr), .o_mem_wdata(be_mem_wdata), .o_prog_rdy(be_prog_rdy),
      .o_busy(be_busy), .o_err(be_err), .o_n_words(be_n_words), .o_bank(be_bank),
      .o_state(be_state));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   int             m_phase = 0;   // 0 idle,1 data,2 checksum,3 response,4 done
   int             m_hdr = 0;
   int             m_cyc = 0;
   int             m_last = 0;
   bit             m_ack = 1'b0;
   byte unsigned   m_q[$];
   logic           e_we = 1'b0, e_tx_start = 1'b0, e_prog_rdy = 1'b0, e_err = 1'b0;
   logic [7:0]     e_tx_byte = 8'h00, e_n = 8'h00;
   logic [AW-1:0]  e_addr = '0;
   logic [DW-1:0]  e_wd_le = '0, e_wd_be = '0;
   int             e_bank = 0;

   task automatic model_nak();
      m_ack      = 1'b0;
      m_phase    = 3;
      e_tx_start = 1'b1;
      e_tx_byte  = 8'h15;
      e_err      = 1'b1;
   endtask

   always @(posedge clk) begin
      int base;
      int s;
      m_cyc++;
      e_we       = 1'b0;
      e_tx_start = 1'b0;
      if (!arst_n) begin
         m_phase = 0; m_ack = 1'b0; m_q.delete();
         e_n = 8'h00; e_err = 1'b0; e_prog_rdy = 1'b0; e_tx_byte = 8'h00;
         e_addr = '0; e_wd_le = '0; e_wd_be = '0; e_bank = 0;
      end else begin
         case (m_phase)
            0: if (rx_valid) begin
                  m_hdr = int'(rx_byte);
                  e_n   = rx_byte;
                  e_err = 1'b0;
                  m_q.delete();
                  m_last = m_cyc;
                  if (m_hdr == 0 || m_hdr > DEPTH) model_nak();
                  else m_phase = 1;
               end
            1: if (rx_valid) begin
                  m_last = m_cyc;
                  m_q.push_back(rx_byte);
                  if (m_q.size() % WB == 0) begin
                     base    = m_q.size() - WB;
                     e_we    = 1'b1;
                     e_addr  = AW'(e_bank * DEPTH + base / WB);
                     e_wd_le = '0;
                     e_wd_be = '0;
                     for (int k = 0; k < WB; k++) begin
                        e_wd_le = e_wd_le | (DW'(m_q[base+k]) << (8 * k));
                        e_wd_be = e_wd_be | (DW'(m_q[base+k]) << (8 * (WB - 1 - k)));
                     end
                     if (m_q.size() == m_hdr * WB) m_phase = 2;
                  end
               end else if (m_cyc - m_last == TO) model_nak();
            2: if (rx_valid) begin
                  s = m_hdr;
                  foreach (m_q[i]) s += int'(m_q[i]);
                  if (rx_byte == 8'(s)) begin
                     m_ack = 1'b1; m_phase = 3; e_tx_start = 1'b1; e_tx_byte = 8'h06;
                  end else model_nak();
               end else if (m_cyc - m_last == TO) model_nak();
            3: if (tx_done) begin
                  if (m_ack) begin m_phase = 4; e_prog_rdy = 1'b1; end
                  else m_phase = 0;
               end
            4: if (next_program) begin
                  e_prog_rdy = 1'b0; e_bank = (e_bank + 1) % NB; m_phase = 0;
               end
            default: m_phase = 0;
         endcase
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic e_busy;
         e_busy = (m_phase >= 1 && m_phase <= 3);
         chk("le_mem_we",   64'(le_mem_we),    64'(e_we));
         chk("le_mem_addr", 64'(le_mem_addr),  64'(e_addr));
         chk("le_wdata",    64'(le_mem_wdata), 64'(e_wd_le));
         chk("le_tx_start", 64'(le_tx_start),  64'(e_tx_start));
         chk("le_tx_byte",  64'(le_tx_byte),   64'(e_tx_byte));
         chk("le_prog_rdy", 64'(le_prog_rdy),  64'(e_prog_rdy));
         chk("le_busy",     64'(le_busy),      64'(e_busy));
         chk("le_err",      64'(le_err),       64'(e_err));
         chk("le_n_words",  64'(le_n_words),   64'(e_n));
         chk("le_bank",     64'(le_bank),      64'(e_bank));
         chk("le_state",    64'(le_state),     64'(m_phase));
         chk("be_mem_we",   64'(be_mem_we),    64'(e_we));
         chk("be_mem_addr", 64'(be_mem_addr),  64'(e_addr));
         chk("be_wdata",    64'(be_mem_wdata), 64'(e_wd_be));
         chk("be_tx_start", 64'(be_tx_start),  64'(e_tx_start));
         chk("be_tx_byte",  64'(be_tx_byte),   64'(e_tx_byte));
         chk("be_prog_rdy", 64'(be_prog_rdy),  64'(e_prog_rdy));
         chk("be_err",      64'(be_err),       64'(e_err));
         chk("be_bank",     64'(be_bank),      64'(e_bank));
         chk("be_state",    64'(be_state),     64'(m_phase));
      end
   end

   // ---------------- write capture for literal checks ----------------
   logic [AW-1:0] cap_addr[$];
   logic [DW-1:0] cap_le[$];
   logic [DW-1:0] cap_be[$];

   always @(negedge clk) begin
      if (le_mem_we === 1'b1) begin
         cap_addr.push_back(le_mem_addr);
         cap_le.push_back(le_mem_wdata);
         cap_be.push_back(be_mem_wdata);
      end
   end

   task automatic clear_cap();
      cap_addr.delete(); cap_le.delete(); cap_be.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1; rx_byte = b;
      tick(1);
      rx_valid = 1'b0;
      tick(1);
   endtask

   task automatic send_list(input logic [7:0] f[$]);
      foreach (f[i]) send(f[i]);
   endtask

   task automatic tx_ack();
      tick(2);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      tick(1);
   endtask

   task automatic pulse_next();
      next_program = 1'b1;
      tick(1);
      next_program = 1'b0;
      tick(1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [7:0] q[$];
      arst_n = 1'b0;
      tick(3);
      chk_en = 1'b1;
      chk("rst_state",    64'(le_state),    64'(0));
      chk("rst_prog_rdy", 64'(le_prog_rdy), 64'(0));
      chk("rst_tx_byte",  64'(le_tx_byte),  64'(0));
      arst_n = 1'b1;
      tick(2);

      // documented frame, bank 0
      clear_cap();
      q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
      send_list(q);
      chk("A_tx_byte", 64'(le_tx_byte), 64'(8'h06));
      tx_ack();
      chk("A_writes",   64'(cap_addr.size()), 64'(1));
      chk("A_addr",     64'(cap_addr[0]),     64'(0));
      chk("A_wdata_le", 64'(cap_le[0]),       64'(32'h44332211));
      chk("A_wdata_be", 64'(cap_be[0]),       64'(32'h11223344));
      chk("A_prog_rdy", 64'(le_prog_rdy),     64'(1));
      chk("A_state",    64'(le_state),        64'(4));
      chk("A_n_words",  64'(le_n_words),      64'(1));

      // bytes in DONE are dropped
      send(8'h55);
      chk("done_drop_writes", 64'(cap_addr.size()), 64'(1));
      chk("done_drop_state",  64'(le_state),        64'(4));

      pulse_next();
      chk("next_bank",     64'(le_bank),     64'(1));
      chk("next_prog_rdy", 64'(le_prog_rdy), 64'(0));

      // two-word frame into bank 1
      clear_cap();
      q = {8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
      send_list(q);
      tx_ack();
      chk("B_writes", 64'(cap_addr.size()), 64'(2));
      chk("B_addr0",  64'(cap_addr[0]),     64'(64));
      chk("B_addr1",  64'(cap_addr[1]),     64'(65));
      chk("B_word0",  64'(cap_le[0]),       64'(32'h04030201));
      chk("B_word1",  64'(cap_le[1]),       64'(32'h08070605));
      chk("B_prog",   64'(le_prog_rdy),     64'(1));
      pulse_next();
      chk("wrap_bank", 64'(le_bank), 64'(0));

      // bad checksum
      clear_cap();
      q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
      send_list(q);
      chk("bad_tx_byte", 64'(le_tx_byte), 64'(8'h15));
      chk("bad_err",     64'(le_err),     64'(1));
      tx_ack();
      chk("bad_state",    64'(le_state),        64'(0));
      chk("bad_prog_rdy", 64'(le_prog_rdy),     64'(0));
      chk("bad_writes",   64'(cap_addr.size()), 64'(1));

      // illegal headers
      clear_cap();
      send(8'h00);
      chk("h00_state",   64'(le_state),   64'(3));
      chk("h00_tx_byte", 64'(le_tx_byte), 64'(8'h15));
      tx_ack();
      send(8'h41);
      chk("h41_state", 64'(le_state), 64'(3));
      tx_ack();
      chk("hdr_writes", 64'(cap_addr.size()), 64'(0));
      chk("hdr_state",  64'(le_state),        64'(0));

      // timeout after two data bytes
      clear_cap();
      send(8'h01);
      chk("to_err_cleared", 64'(le_err), 64'(0));
      send(8'h11);
      send(8'h22);
      tick(98);
      chk("to_not_yet", 64'(le_state), 64'(1));
      tick(1);
      chk("to_state",    64'(le_state),        64'(3));
      chk("to_tx_start", 64'(le_tx_start),     64'(1));
      chk("to_tx_byte",  64'(le_tx_byte),      64'(8'h15));
      chk("to_err",      64'(le_err),          64'(1));
      chk("to_writes",   64'(cap_addr.size()), 64'(0));
      tx_ack();

      // reset in the middle of a bank-1 frame
      q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
      send_list(q);
      tx_ack();
      pulse_next();
      send(8'h02);
      send(8'hA1);
      send(8'hA2);
      send(8'hA3);
      arst_n = 1'b0;
      tick(1);
      chk("mrst_state",   64'(le_state),     64'(0));
      chk("mrst_busy",    64'(le_busy),      64'(0));
      chk("mrst_bank",    64'(le_bank),      64'(0));
      chk("mrst_n_words", 64'(le_n_words),   64'(0));
      chk("mrst_tx_byte", 64'(le_tx_byte),   64'(0));
      chk("mrst_wdata",   64'(le_mem_wdata), 64'(0));
      clear_cap();
      send(8'hA4);
      send(8'hA5);
      arst_n = 1'b1;
      tick(1);
      chk("mrst_writes", 64'(cap_addr.size()), 64'(0));

      // clean frame after reset lands in bank 0
      q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
      send_list(q);
      tx_ack();
      chk("post_writes", 64'(cap_addr.size()), 64'(1));
      chk("post_addr",   64'(cap_addr[0]),     64'(0));
      chk("post_prog",   64'(le_prog_rdy),     64'(1));
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
